// File: rtl/shift_seq_pkg.sv
// Shared definitions for the operand-2 shift sequencer: shift-type codes,
// FSM state encoding and bit positions inside the 12-bit op2 field.
package shift_seq_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RS_RD   = 3'd1;
  localparam logic [2:0] ST_RS_WAIT = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int unsigned OP2_RS_LSB    = 8;   // Rs index / rotate field [11:8]
  localparam int unsigned OP2_SHAMT_LSB = 7;   // immediate shift amount [11:7]
  localparam int unsigned OP2_TYPE_LSB  = 5;   // shift type [6:5]
  localparam int unsigned OP2_REG_BIT   = 4;   // 1 = shift amount from Rs

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Barrel shifter datapath with register-shift semantics: amount 0 passes
// the operand and carry through; LSL/LSR/ASR saturate beyond 32.
module shift_sequencer_shifter
  import shift_seq_pkg::*;
(
  input  logic [31:0] operand,
  input  logic [7:0]  amount,
  input  logic [1:0]  shift_type,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out
);

  logic [32:0] lsl_ext;
  logic [32:0] lsr_ext;
  logic [32:0] asr_ext;
  logic [4:0]  rot;
  logic [31:0] ror_val;

  // One extra bit on the shifted-out side yields the carry for free
  assign lsl_ext = {1'b0, operand} << amount;
  assign lsr_ext = {operand, 1'b0} >> amount;
  assign asr_ext = $signed({operand, 1'b0}) >>> amount;
  assign rot     = amount[4:0];
  assign ror_val = (operand >> rot) | (operand << (6'd32 - {1'b0, rot}));

  always_comb begin
    result    = operand;
    carry_out = carry_in;
    if (amount != '0) begin
      case (shift_type)
        SH_LSL:  {carry_out, result} = lsl_ext;
        SH_LSR:  {result, carry_out} = lsr_ext;
        SH_ASR:  {result, carry_out} = asr_ext;
        default: begin
          result    = ror_val;
          carry_out = ror_val[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Operand-2 shift sequencer: captures a request, optionally reads Rs from the
// register file, runs the shifter and holds the result until consumed.
// Register-specified shifts are built only with SHIFT_SEQ_REG_SHIFT_EN defined.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned REGF_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] op2_field,
  input  logic        i_flag,
  input  logic [31:0] rm_data,
  input  logic        carry_in,
  output logic        rs_rd_en,
  output logic [3:0]  rs_rd_addr,
  input  logic [31:0] rs_rd_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_carry,
  output logic        res_undef,
  output logic        busy
);

  localparam logic [2:0] LAT_M1 = 3'(REGF_LAT - 1);

  logic [2:0]  state;
  logic [11:0] op2_q;
  logic        imm_q;
  logic [31:0] rm_q;
  logic        c_q;
  logic        reg_shift_q;

  logic [31:0] sh_operand;
  logic [7:0]  sh_amount;
  logic [1:0]  sh_type;
  logic [31:0] sh_result;
  logic        sh_carry;
  logic [31:0] nxt_data;
  logic        nxt_carry;
  logic        nxt_undef;

  assign reg_shift_q = !imm_q && op2_q[OP2_REG_BIT];

`ifdef SHIFT_SEQ_REG_SHIFT_EN
  logic [2:0] wait_cnt;
  logic [7:0] rs_amt_q;
  logic [3:0] rs_addr_q;
  logic       is_reg_shift;
  logic       unused_rs;

  assign is_reg_shift = !i_flag && op2_field[OP2_REG_BIT];
  assign rs_rd_en     = (state == ST_RS_RD);
  assign rs_rd_addr   = rs_addr_q;
  assign unused_rs    = ^rs_rd_data[31:8];
`else
  logic unused_rs;

  assign rs_rd_en   = 1'b0;
  assign rs_rd_addr = '0;
  assign unused_rs  = ^{rs_rd_data, LAT_M1};
`endif

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_DONE);

  // Immediate operands are rotates of imm8; immediate LSR/ASR #0 mean #32
  always_comb begin
    sh_operand = rm_q;
    sh_type    = op2_q[OP2_TYPE_LSB +: 2];
    sh_amount  = {3'b000, op2_q[OP2_SHAMT_LSB +: 5]};
    if (imm_q) begin
      sh_operand = {24'd0, op2_q[7:0]};
      sh_type    = SH_ROR;
      sh_amount  = {3'b000, op2_q[OP2_RS_LSB +: 4], 1'b0};
    end else if (op2_q[OP2_REG_BIT]) begin
`ifdef SHIFT_SEQ_REG_SHIFT_EN
      sh_amount = rs_amt_q;
`else
      sh_amount = '0;
`endif
    end else if (op2_q[OP2_SHAMT_LSB +: 5] == '0 &&
                 (sh_type == SH_LSR || sh_type == SH_ASR)) begin
      sh_amount = 8'd32;
    end
  end

  shift_sequencer_shifter u_shifter (
    .operand    (sh_operand),
    .amount     (sh_amount),
    .shift_type (sh_type),
    .carry_in   (c_q),
    .result     (sh_result),
    .carry_out  (sh_carry)
  );

  // RRX bypasses the shifter; unsupported register shifts flag undef
  always_comb begin
    nxt_data  = sh_result;
    nxt_carry = sh_carry;
    nxt_undef = 1'b0;
    if (!imm_q && !op2_q[OP2_REG_BIT] && op2_q[OP2_TYPE_LSB +: 2] == SH_ROR &&
        op2_q[OP2_SHAMT_LSB +: 5] == '0) begin
      nxt_data  = {c_q, rm_q[31:1]};
      nxt_carry = rm_q[0];
    end
`ifndef SHIFT_SEQ_REG_SHIFT_EN
    if (reg_shift_q) begin
      nxt_data  = '0;
      nxt_carry = c_q;
      nxt_undef = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op2_q     <= '0;
      imm_q     <= 1'b0;
      rm_q      <= '0;
      c_q       <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_undef <= 1'b0;
`ifdef SHIFT_SEQ_REG_SHIFT_EN
      wait_cnt  <= '0;
      rs_amt_q  <= '0;
      rs_addr_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op2_q <= op2_field;
            imm_q <= i_flag;
            rm_q  <= rm_data;
            c_q   <= carry_in;
`ifdef SHIFT_SEQ_REG_SHIFT_EN
            state     <= is_reg_shift ? ST_RS_RD : ST_EXEC;
            rs_addr_q <= is_reg_shift ? op2_field[OP2_RS_LSB +: 4] : '0;
`else
            state <= ST_EXEC;
`endif
          end
        end
`ifdef SHIFT_SEQ_REG_SHIFT_EN
        ST_RS_RD: begin
          wait_cnt <= LAT_M1;
          state    <= ST_RS_WAIT;
        end
        ST_RS_WAIT: begin
          if (wait_cnt == '0) begin
            rs_amt_q <= rs_rd_data[7:0];
            state    <= ST_EXEC;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
`else
        ST_RS_RD, ST_RS_WAIT: state <= ST_IDLE;
`endif
        ST_EXEC: begin
          res_data  <= nxt_data;
          res_carry <= nxt_carry;
          res_undef <= nxt_undef;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
